// File: rtl/fetch_out_queue.sv
// ---------------------------------------------------------------------------
// fetch_out_queue
//   Instruction queue between fetch and decode. It is a circular buffer of
//   DEPTH entries, and each entry holds {pc, inst, pred}. Fetch pushes at the
//   rear and decode pops at the front. The head entry is presented on out_*.
//
//   Optional feature, enabled by defining the macro FOQ_BYPASS_EN:
//     When the queue is empty, a pushed instruction is shown on out_* in the
//     same cycle. If decode accepts it in that cycle, it never gets written.
//   In the default build (macro undefined) there is no combinational path
//   from push_* to out_*. A push becomes visible one cycle later.
//
// Ports
//   clk_in      : clock, all state updates on the rising edge
//   rst_in      : asynchronous active-low reset (clears pointers and storage)
//   rdy_in      : global ready; when low, all state freezes and flush is ignored
//   flush       : mispredict; clears the queue and drops same-cycle push/pop
//   push_valid  : fetch offers an instruction
//   push_inst   : instruction word (16-bit forms arrive zero-extended)
//   push_pc     : instruction address
//   push_pred   : predictor need_branch bit
//   foq_full    : queue holds DEPTH entries; fetch and predictor stall
//   pop_ready   : decoder accepts the head this cycle
//   out_valid   : head entry valid
//   out_inst    : head instruction (0 when not valid)
//   out_pc      : head address (0 when not valid)
//   out_pred    : head prediction bit (0 when not valid)
// ---------------------------------------------------------------------------
module fetch_out_queue #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        push_valid,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  input  logic        push_pred,
  output logic        foq_full,
  input  logic        pop_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred
);

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] inst;
  } foq_ent_t;

  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W+1)'(DEPTH);

  foq_ent_t [DEPTH-1:0] r_mem;
  logic [DEPTH_W-1:0]   r_front;
  logic [DEPTH_W-1:0]   r_rear;
  logic [DEPTH_W:0]     r_count;

  logic     w_empty;
  logic     w_byp;       // bypass candidate: empty queue, live push
  logic     w_byp_take;  // bypass consumed directly by decode
  logic     w_push;
  logic     w_pop;
  foq_ent_t w_head;
  foq_ent_t w_in;

  assign w_empty  = (r_count == '0);
  assign foq_full = (r_count == CNT_FULL);
  assign w_head   = r_mem[r_front];
  assign w_in     = '{pred: push_pred, pc: push_pc, inst: push_inst};

`ifdef FOQ_BYPASS_EN
  // rst_in is included so that a push offered during reset is not visible.
  assign w_byp = rst_in && rdy_in && w_empty && push_valid && !flush;
`else
  assign w_byp = 1'b0;
`endif
  assign w_byp_take = w_byp && pop_ready;

  // A bypassed instruction that decode accepts in the same cycle is consumed
  // without being written. Full blocks a push even when a pop happens in the
  // same cycle.
  assign w_push = rdy_in && push_valid && !foq_full && !flush && !w_byp_take;
  // A pop only retires stored entries. A bypass hit is not a queue pop.
  assign w_pop  = rdy_in && !w_empty && pop_ready && !flush;

  always_comb begin
    out_valid = 1'b0;
    out_inst  = '0;
    out_pc    = '0;
    out_pred  = 1'b0;
    if (rdy_in && !w_empty) begin
      out_valid = 1'b1;
      out_inst  = w_head.inst;
      out_pc    = w_head.pc;
      out_pred  = w_head.pred;
    end else if (w_byp) begin
      out_valid = 1'b1;
      out_inst  = push_inst;
      out_pc    = push_pc;
      out_pred  = push_pred;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_mem   <= '0;
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        // Storage contents are left in place. Once the pointers are reset,
        // the old entries can no longer be reached.
        r_front <= '0;
        r_rear  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_rear] <= w_in;
          r_rear        <= r_rear + PTR_ONE;
        end
        if (w_pop) r_front <= r_front + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_out_queue.md
FETCH_OUT_QUEUE -- requirements
Module: fetch_out_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-002 SHALL have parameter DEPTH_W, default 3, log2(DEPTH).
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global ready; low = pause.
REQ-006 SHALL have port flush  input  1  predictor mispredict (predict_fail) clears queue.
REQ-007 SHALL have port push_valid  input  1  fetch offers an instruction.
REQ-008 SHALL have port push_inst  input  32  instruction word (16-bit forms zero-extended).
REQ-009 SHALL have port push_pc  input  32  instruction address.
REQ-010 SHALL have port push_pred  input  1  predictor need_branch for this instruction.
REQ-011 SHALL have port foq_full  output  1  queue full; fetch and predictor stall.
REQ-012 SHALL have port pop_ready  input  1  decoder accepts head this cycle.
REQ-013 SHALL have port out_valid  output  1  head entry valid.
REQ-014 SHALL have port out_inst  output  32  head instruction.
REQ-015 SHALL have port out_pc  output  32  head address.
REQ-016 SHALL have port out_pred  output  1  head prediction bit.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries {pc, inst, pred} with front, rear (DEPTH_W bits) and count (DEPTH_W+1 bits).
REQ-018 foq_full SHALL equal (count == DEPTH), combinational from registered count only.
REQ-019 A push SHALL occur on an edge with rdy_in && push_valid && !foq_full && !flush; entry written at rear, rear increments modulo DEPTH.
REQ-020 A pop SHALL occur on an edge with rdy_in && out_valid && pop_ready && !flush; front increments modulo DEPTH.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push alone +1; pop alone -1.
REQ-022 When full, push SHALL be rejected even if a pop occurs the same cycle.
REQ-023 Pop when empty SHALL be ignored; count never underflows or exceeds DEPTH.
REQ-024 out_valid SHALL equal (count != 0) when rdy_in is high, else 0; out_inst/out_pc/out_pred SHALL show entry at front when out_valid, else 0.
REQ-025 Push-to-visible latency SHALL be one cycle (without bypass).
REQ-026 flush SHALL take priority over everything: next edge sets front=rear=count=0; the same-cycle push and pop are discarded.
REQ-027 rdy_in low SHALL freeze all state; flush is also ignored while rdy_in is low.
REQ-028 Entry order SHALL be strict FIFO; wrap-around at DEPTH-1 -> 0 on both pointers.

Reset
REQ-029 rst_in low SHALL immediately (asynchronously) clear front, rear, count and all entry storage to 0.
REQ-030 During and after reset: foq_full=0, out_valid=0, out_inst=out_pc=0, out_pred=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; no partial push completes.

Configuration
REQ-032 Macro FOQ_BYPASS_EN SHALL enable empty-queue bypass.
REQ-033 With FOQ_BYPASS_EN: when count==0, rdy_in, push_valid, !flush, out_valid=1 and out_* SHALL show push_* combinationally; if pop_ready, entry is consumed without write and count stays 0.
REQ-034 With FOQ_BYPASS_EN, bypass not taken (pop_ready low) SHALL store the entry normally.
REQ-035 Without FOQ_BYPASS_EN: no combinational path push_* -> out_*; REQ-025 latency applies.

Verification
REQ-036 Reset: rst_in low mid-fill of 5 entries -> count=0, out_valid=0, foq_full=0 immediately.
REQ-037 Fill: 8 pushes, pop_ready=0 -> foq_full=1 after 8th edge; 9th push (pc=0x20) dropped; pops return pcs 0x0..0x1C in order.
REQ-038 Full + push + pop same cycle -> push rejected, count 8->7.
REQ-039 Flush with count=5 and push_valid=1 same cycle -> count=0, out_valid=0 next cycle; following push pc=0x100 appears as head.
REQ-040 Wrap: 12 pushes interleaved with 12 pops -> all pc/inst/pred match in order across pointer wrap; rdy_in low 3 cycles mid-stream -> no state change.
REQ-041 FOQ_BYPASS_EN: empty queue, push pc=0x40 with pop_ready=1 -> out_valid=1, out_pc=0x40 same cycle, count stays 0; without macro -> out_pc=0x40 one cycle later.
